truth_table_sweeper: RTL

//  Sequencer that exhaustively exercises a 4-input combinational function block (F = A&(C&D | B) | B&~C).

---
 rtl/truth_table_pkg.sv | 18 +
 rtl/truth_table_sweeper_if.sv | 29 ++
 rtl/sweep_settle_timer.sv | 29 ++
 rtl/truth_table_sweeper.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and defaults for the truth-table sweeper: FSM state encoding and the
// expected truth table of F = A&(C&D | B) | B&~C.
package truth_table_pkg;

   localparam int unsigned N_IN_DEF   = 4;
   localparam int unsigned SETTLE_DEF = 2;

   // Bit i is F for input vector {A,B,C,D} = i, A being the MSB.
   localparam logic [15:0] EXP_TABLE_DEF = 16'hF830;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Test-controller side of the sweeper: start/abort requests and the sweep status/results.
interface truth_table_sweeper_if
   import truth_table_pkg::*;
#(
   parameter int unsigned N_IN = N_IN_DEF
);

   logic            start;
   logic            abort;
   logic            busy;
   logic            done;
   logic            pass;
   logic            aborted;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_err_idx;

   // Test controller view
   modport master (
      output start, abort,
      input  busy, done, pass, aborted, err_count, first_err_idx
   );

   // Sweeper view
   modport slave (
      input  start, abort,
      output busy, done, pass, aborted, err_count, first_err_idx
   );

endinterface

// File: rtl/sweep_settle_timer.sv
// Settle-time down-counter: loads SETTLE-1, decrements on request, flags when it reaches zero.
module sweep_settle_timer #(
   parameter int unsigned SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic expired_c
);

   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input vectors of a 4-input combinational block, samples F after a settle time and
// compares it with the expected truth table, keeping a mismatch count and the first failing index.
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int unsigned          N_IN      = N_IN_DEF,
   parameter int unsigned          SETTLE    = SETTLE_DEF,
   parameter logic [2**N_IN-1:0]   EXP_TABLE = EXP_TABLE_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   truth_table_sweeper_if.slave ctl,
   input  logic                f_in,
   output logic [N_IN-1:0]     vec_out
);

   localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] first_q, first_d;
   logic            pass_q, pass_d;
   logic            aborted_q, aborted_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            tmr_load_c;
   logic            tmr_dec_c;
   logic            tmr_expired_c;

   sweep_settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (tmr_load_c),
      .dec       (tmr_dec_c),
      .expired_c (tmr_expired_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         err_q     <= '0;
         first_q   <= '0;
         pass_q    <= 1'b0;
         aborted_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         first_q   <= first_d;
         pass_q    <= pass_d;
         aborted_q <= aborted_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and result update; done is registered so it is high exactly while in ST_DONE.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      err_d      = err_q;
      first_d    = first_q;
      pass_d     = pass_q;
      aborted_d  = aborted_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tmr_load_c = 1'b0;
      tmr_dec_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ctl.start) begin
               idx_d      = '0;
               err_d      = '0;
               first_d    = '0;
               pass_d     = 1'b0;
               aborted_d  = 1'b0;
               busy_d     = 1'b1;
               tmr_load_c = 1'b1;
               state_d    = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (ctl.abort) begin
               aborted_d = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else if (tmr_expired_c) begin
               state_d = ST_SAMPLE;
            end else begin
               tmr_dec_c = 1'b1;
            end
         end

         ST_SAMPLE: begin
            // Abort wins over the compare: the sample taken in this cycle is discarded.
            if (ctl.abort) begin
               aborted_d = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else begin
               if (f_in ^ EXP_TABLE[idx_q]) begin
                  err_d = err_q + 1'b1;
                  if (err_q == '0) begin
                     first_d = idx_q;
                  end
               end
               if (idx_q == IDX_LAST) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d      = idx_q + 1'b1;
                  tmr_load_c = 1'b1;
                  state_d    = ST_WAIT;
               end
            end
         end

         ST_DONE: begin
            pass_d  = (err_q == '0) && !aborted_q;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign vec_out           = idx_q;
   assign ctl.busy          = busy_q;
   assign ctl.done          = done_q;
   assign ctl.pass          = pass_q;
   assign ctl.aborted       = aborted_q;
   assign ctl.err_count     = err_q;
   assign ctl.first_err_idx = first_q;

endmodule
